// File: rtl/shft_pkg.sv
// Shared types and constants for the serial shift receiver/transmitter pair.
package shft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shft_state_t;

  localparam int   SHFT_W_DEF = 8;
  localparam logic DIR_RIGHT  = 1'b1;  // LSB arrives first
  localparam logic DIR_LEFT   = 1'b0;  // MSB arrives first

endpackage

// File: rtl/shft_rx.sv
// Serial-to-parallel receiver: assembles W-bit frames from a strobed bit
// stream, shifting right (LSB first) or left (MSB first), with abort (clr).
// Optional even-parity checking is built when SHFT_RX_PARITY_EN is defined;
// the parity bit follows the data bits and is not shifted into the word.
module shft_rx
  import shft_pkg::*;
#(
  parameter int W = SHFT_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         din,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         busy,
  output logic         perr
);

`ifdef SHFT_RX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam int            CW   = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  shft_state_t   r_state;
  shft_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sreg;
  logic [W-1:0]  r_dout;
  logic          r_dir;
  logic          r_vld;
  logic          w_take;   // a bit is accepted this cycle
  logic          w_first;  // the accepted bit is bit 0 of a frame
  logic          w_dir;    // direction in force for the accepted bit
  logic          w_shift;  // the accepted bit is a data bit
  logic [W-1:0]  w_sreg_shifted;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and bit acceptance; clr overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_first      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (en) begin
          w_take       = 1'b1;
          w_first      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          w_take = 1'b1;
          if (r_cnt == LAST) w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (clr) begin
      w_state_next = IDLE;
      w_take       = 1'b0;
      w_first      = 1'b0;
    end
  end

  assign w_dir          = w_first ? dir : r_dir;
  assign w_sreg_shifted = (w_dir == DIR_RIGHT) ? {din, r_sreg[W-1:1]}
                                               : {r_sreg[W-2:0], din};

`ifdef SHFT_RX_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX = CW'(W);
  assign w_shift = w_take && (w_first || (r_cnt != PAR_IDX));
`else
  assign w_shift = w_take;
`endif

  // Datapath: direction latch, shift register, saturating bit counter, output word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_sreg <= '0;
      r_dout <= '0;
      r_dir  <= DIR_RIGHT;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (clr) begin
        r_cnt  <= '0;
        r_sreg <= '0;
      end else begin
        if (w_first) r_dir  <= dir;
        if (w_shift) r_sreg <= w_sreg_shifted;
        if (w_first)                   r_cnt <= CW'(1);
        else if (r_state == DONE)      r_cnt <= '0;
        else if (w_take && r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
        // Stale sreg bits are fully replaced after W shifts, so a new frame
        // may start shifting in the same cycle the finished word is copied.
        if (r_state == DONE) begin
          r_dout <= r_sreg;
          r_vld  <= 1'b1;
        end
      end
    end
  end

`ifdef SHFT_RX_PARITY_EN
  logic r_par;
  logic r_perr;

  // Running XOR over all frame bits (data + parity), published on DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else if (clr) begin
      r_par <= 1'b0;
    end else begin
      if (w_take)           r_par  <= (w_first ? 1'b0 : r_par) ^ din;
      if (r_state == DONE)  r_perr <= r_par;
    end
  end

  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif

  assign dout = r_dout;
  assign vld  = r_vld;
  assign busy = (r_state != IDLE);

endmodule
